// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush controller: load-use, branch redirect, multi-cycle MDU hold, fetch wait/timeout.
// Stall/flush outputs are combinational; state, counters and fetch_err are registered.
module hazard_sequencer #(
  parameter int MDU_LAT       = 4,
  parameter int FETCH_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] RdE,
  input  logic       LoadE,
  input  logic       PCSrcE,
  input  logic       MduE,
  input  logic       imem_valid,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       StallE,
  output logic       FlushE,
  output logic       FlushM,
  output logic       mdu_done,
  output logic       fetch_err,
  output logic       busy
);

  typedef enum logic {RUN, MDU_BUSY} state_t;

  localparam logic [3:0] MDU_INIT = 4'(MDU_LAT - 2);
  localparam logic [7:0] TO_LAST  = 8'(FETCH_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] mdu_cnt_q, mdu_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       fetch_err_q, fetch_err_d;

  logic lu;
  logic stall_f, stall_d, flush_d, stall_e, flush_e, flush_m, done;

  assign lu = LoadE & (RdE != 5'd0) & ((Rs1D == RdE) | (Rs2D == RdE));

  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    stall_e   = 1'b0;
    flush_e   = 1'b0;
    flush_m   = 1'b0;
    done      = 1'b0;
    case (state_q)
      RUN: begin
        if (PCSrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (MduE) begin
          stall_f   = 1'b1;
          stall_d   = 1'b1;
          stall_e   = 1'b1;
          flush_m   = 1'b1;
          mdu_cnt_d = MDU_INIT;
          state_d   = MDU_BUSY;
        end else if (lu) begin
          // A load-use stall outranks the fetch-wait bubble in Decode.
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end else if (!imem_valid) begin
          stall_f = 1'b1;
          flush_d = 1'b1;
        end
      end
      MDU_BUSY: begin
        if (mdu_cnt_q != 4'd0) begin
          stall_f   = 1'b1;
          stall_d   = 1'b1;
          stall_e   = 1'b1;
          flush_m   = 1'b1;
          mdu_cnt_d = mdu_cnt_q - 4'd1;
        end else begin
          done    = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    fetch_err_d = fetch_err_q;
    if (imem_valid) begin
      wait_cnt_d = 8'd0;
    end else begin
      if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
      if (wait_cnt_q == TO_LAST) fetch_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      mdu_cnt_q   <= 4'd0;
      wait_cnt_q  <= 8'd0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mdu_cnt_q   <= mdu_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Qualify with rst so controls drop the instant reset asserts.
  assign StallF    = rst & stall_f;
  assign StallD    = rst & stall_d;
  assign FlushD    = rst & flush_d;
  assign StallE    = rst & stall_e;
  assign FlushE    = rst & flush_e;
  assign FlushM    = rst & flush_m;
  assign mdu_done  = rst & done;
  assign busy      = rst & (state_q == MDU_BUSY);
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: vector table plus hand-written MDU/reset sequences, scoreboard queue.
module tb_hazard_sequencer;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       load;
    logic       pc;
    logic       mdu;
    logic       iv;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [8:0] exp;
  } vec_t;

  typedef struct {
    bit         sel;
    string      name;
    logic [8:0] exp;
  } sb_t;

  // Output vector order: StallF StallD FlushD StallE FlushE FlushM mdu_done fetch_err busy
  localparam logic [8:0] E0    = 9'b000000000;
  localparam logic [8:0] ELU   = 9'b110010000;
  localparam logic [8:0] EBR   = 9'b001010000;
  localparam logic [8:0] EFW   = 9'b101000000;
  localparam logic [8:0] EMDU  = 9'b110101000;
  localparam logic [8:0] EDONE = 9'b000000100;
  localparam logic [8:0] ERR   = 9'b000000010;
  localparam logic [8:0] BSY   = 9'b000000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  in_t  in_a, in_b;
  logic sf_a, sd_a, fd_a, se_a, fe_a, fm_a, dn_a, er_a, by_a;
  logic sf_b, sd_b, fd_b, se_b, fe_b, fm_b, dn_b, er_b, by_b;

  hazard_sequencer #(.MDU_LAT(4), .FETCH_TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .Rs1D(in_a.rs1), .Rs2D(in_a.rs2), .RdE(in_a.rd),
    .LoadE(in_a.load), .PCSrcE(in_a.pc), .MduE(in_a.mdu), .imem_valid(in_a.iv),
    .StallF(sf_a), .StallD(sd_a), .FlushD(fd_a), .StallE(se_a), .FlushE(fe_a),
    .FlushM(fm_a), .mdu_done(dn_a), .fetch_err(er_a), .busy(by_a)
  );

  hazard_sequencer #(.MDU_LAT(2), .FETCH_TIMEOUT(64)) dut_b (
    .clk(clk), .rst(rst), .Rs1D(in_b.rs1), .Rs2D(in_b.rs2), .RdE(in_b.rd),
    .LoadE(in_b.load), .PCSrcE(in_b.pc), .MduE(in_b.mdu), .imem_valid(in_b.iv),
    .StallF(sf_b), .StallD(sd_b), .FlushD(fd_b), .StallE(se_b), .FlushE(fe_b),
    .FlushM(fm_b), .mdu_done(dn_b), .fetch_err(er_b), .busy(by_b)
  );

  int   checks = 0;
  int   errors = 0;
  sb_t  sb_q[$];
  vec_t tbl[$];

  function automatic in_t mk(logic r, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                             logic load, logic pc, logic mdu, logic iv);
    in_t t;
    t.rst = r; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
    t.load = load; t.pc = pc; t.mdu = mdu; t.iv = iv;
    return t;
  endfunction

  function automatic void add(string nm, in_t in, logic [8:0] exp);
    vec_t v;
    v.name = nm; v.in = in; v.exp = exp;
    tbl.push_back(v);
  endfunction

  task automatic check_one(string nm, logic [8:0] got, logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
    checks++;
    if ((got[7] & got[6]) !== 1'b0 || (got[5] & got[4]) !== 1'b0) begin
      errors++;
      $display("FAIL %s_invariant: got %b expected no stall+flush pair", nm, got);
    end
  endtask

  // Drive one cycle of stimulus on the selected DUT, idle the other, check at negedge.
  task automatic step(bit sel, string nm, in_t in, logic [8:0] exp);
    sb_t  e;
    sb_t  p;
    in_t  idle;
    logic [8:0] obs;
    idle = mk(in.rst, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst  = in.rst;
    if (sel) begin in_b = in; in_a = idle; end
    else     begin in_a = in; in_b = idle; end
    e.sel = sel; e.name = nm; e.exp = exp;
    sb_q.push_back(e);
    @(negedge clk);
    p = sb_q.pop_front();
    if (p.sel) obs = {sf_b, sd_b, fd_b, se_b, fe_b, fm_b, dn_b, er_b, by_b};
    else       obs = {sf_a, sd_a, fd_a, se_a, fe_a, fm_a, dn_a, er_a, by_a};
    check_one(p.name, obs, p.exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    in_a = mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    in_b = in_a;
    #2;

    add("reset",   mk(0, 5'd5, 5'd0, 5'd5, 1, 1, 1, 0), E0);
    add("idle",    mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1), E0);
    add("lu_rs1",  mk(1, 5'd5, 5'd0, 5'd5, 1, 0, 0, 1), ELU);
    add("lu_rd0",  mk(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1), E0);
    add("lu_rs2",  mk(1, 5'd3, 5'd9, 5'd9, 1, 0, 0, 1), ELU);
    add("noload",  mk(1, 5'd9, 5'd0, 5'd9, 0, 0, 0, 1), E0);
    add("br_lu",   mk(1, 5'd0, 5'd7, 5'd7, 1, 1, 0, 1), EBR);
    add("fw1",     mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0), EFW);
    add("fw2",     mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0), EFW);
    add("fw_lu",   mk(1, 5'd5, 5'd0, 5'd5, 1, 0, 0, 0), ELU);
    add("fw_ok",   mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1), E0);
    add("fw_br",   mk(1, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0), EBR);
    add("fw_ok2",  mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1), E0);
    add("to1",     mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0), EFW);
    add("to2",     mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0), EFW);
    add("to3",     mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0), EFW);
    add("to4",     mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0), EFW);
    add("to_err",  mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1), ERR);
    add("to_stky", mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1), ERR);

    foreach (tbl[i]) step(1'b0, tbl[i].name, tbl[i].in, tbl[i].exp);

    // MDU_LAT=4: three stall cycles, then release; redirect/load-use/fetch wait ignored while busy.
    step(1'b0, "mdu4_c1",   mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1), EMDU | ERR);
    step(1'b0, "mdu4_c2",   mk(1, 5'd5, 5'd0, 5'd5, 1, 1, 1, 1), EMDU | ERR | BSY);
    step(1'b0, "mdu4_c3",   mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0), EMDU | ERR | BSY);
    step(1'b0, "mdu4_done", mk(1, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0), EDONE | ERR | BSY);
    step(1'b0, "mdu4_run",  mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1), ERR);

    // MDU_LAT=2: one stall cycle, then release.
    step(1'b1, "mdu2_c1",   mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1), EMDU);
    step(1'b1, "mdu2_done", mk(1, 5'd4, 5'd0, 5'd4, 1, 1, 0, 1), EDONE | BSY);
    step(1'b1, "mdu2_run",  mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1), E0);

    // Reset in the second stall cycle, then a full restart.
    step(1'b0, "rmdu_c1",   mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1), EMDU | ERR);
    step(1'b0, "rmdu_rst",  mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1), E0);
    step(1'b0, "rmdu_r1",   mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1), EMDU);
    step(1'b0, "rmdu_r2",   mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1), EMDU | BSY);
    step(1'b0, "rmdu_r3",   mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1), EMDU | BSY);
    step(1'b0, "rmdu_done", mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1), EDONE | BSY);
    step(1'b0, "rmdu_run",  mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1), E0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
